// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The master side is the pipeline; the slave side is the controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 32
);
  localparam int SELW = $clog2(DEPTH);

  logic              i_mem_stall;
  logic              i_branch_taken;
  logic              i_id_valid;
  logic [REG_AW-1:0] i_id_rs1;
  logic [REG_AW-1:0] i_id_rs2;
  logic [REG_AW-1:0] i_id_rd;
  logic              i_id_use_rs1;
  logic              i_id_use_rs2;
  logic              i_id_reg_write;
  logic              i_id_mem_read;

  logic              o_pc_write;
  logic              o_if_id_write;
  logic              o_if_id_flush;
  logic              o_id_ex_bubble;
  logic [SELW-1:0]   o_fwd_sel_a;
  logic [SELW-1:0]   o_fwd_sel_b;
  logic [CNT_W-1:0]  o_stall_count;
  logic [CNT_W-1:0]  o_flush_count;

  modport master (
    output i_mem_stall, i_branch_taken, i_id_valid,
           i_id_rs1, i_id_rs2, i_id_rd,
           i_id_use_rs1, i_id_use_rs2, i_id_reg_write, i_id_mem_read,
    input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble,
           o_fwd_sel_a, o_fwd_sel_b, o_stall_count, o_flush_count
  );

  modport slave (
    input  i_mem_stall, i_branch_taken, i_id_valid,
           i_id_rs1, i_id_rs2, i_id_rd,
           i_id_use_rs1, i_id_use_rs2, i_id_reg_write, i_id_mem_read,
    output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble,
           o_fwd_sel_a, o_fwd_sel_b, o_stall_count, o_flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, branch flush and operand-forwarding control for an in-order
// pipeline; tracks DEPTH post-ID slots (slot 0 = EX, slot DEPTH-1 = WB).
module pipeline_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int BR_STAGE = 1,
  parameter int CNT_W    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int SELW = $clog2(DEPTH);

  logic              r_vld [DEPTH];
  logic              r_wr  [DEPTH];
  logic              r_ld  [DEPTH];
  logic [REG_AW-1:0] r_rd  [DEPTH];
  logic [REG_AW-1:0] r_rs1 [DEPTH];
  logic [REG_AW-1:0] r_rs2 [DEPTH];
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_haz;
  logic              w_flush;
  logic              w_stall;
  logic              w_load;

  // The youngest in-flight writer of rs decides; a load too young to forward stalls ID.
  function automatic logic load_hazard(input logic use_b, input logic [REG_AW-1:0] rs);
    logic found;
    logic hit;
    found = 1'b0;
    hit   = 1'b0;
    if (use_b && (rs != '0)) begin
      for (int j = 0; j < DEPTH - 1; j++) begin
        if (!found && r_vld[j] && r_wr[j] && (r_rd[j] == rs)) begin
          found = 1'b1;
          hit   = r_ld[j] && (j < LOAD_LAT);
        end
      end
    end
    return hit;
  endfunction

  function automatic logic [SELW-1:0] fwd_pick(input logic [REG_AW-1:0] rs);
    logic [SELW-1:0] sel;
    sel = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (r_vld[k] && r_wr[k] && (r_rd[k] == rs) && (rs != '0)) sel = SELW'(k);
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    w_haz = 1'b0;
    if (bus.i_id_valid) begin
      w_haz = load_hazard(bus.i_id_use_rs1, bus.i_id_rs1) ||
              load_hazard(bus.i_id_use_rs2, bus.i_id_rs2);
    end
  end

  assign w_flush = !bus.i_mem_stall && bus.i_branch_taken;
  assign w_stall = !bus.i_mem_stall && !bus.i_branch_taken && w_haz;
  assign w_load  = !bus.i_mem_stall && !bus.i_branch_taken && !w_haz && bus.i_id_valid;

  // Slot valid bits and event counters: the only state that needs reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_vld[k] <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!bus.i_mem_stall) begin
      r_vld[0] <= w_load;
      for (int k = 1; k < DEPTH; k++) begin
        r_vld[k] <= r_vld[k-1] && !(w_flush && ((k - 1) < BR_STAGE));
      end
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_flush) r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  // Slot payload shifts with the valid bits; unused sources are stored as x0.
  always_ff @(posedge i_clk) begin
    if (!bus.i_mem_stall) begin
      r_wr[0]  <= bus.i_id_reg_write;
      r_ld[0]  <= bus.i_id_mem_read;
      r_rd[0]  <= bus.i_id_rd;
      r_rs1[0] <= (w_load && bus.i_id_use_rs1) ? bus.i_id_rs1 : '0;
      r_rs2[0] <= (w_load && bus.i_id_use_rs2) ? bus.i_id_rs2 : '0;
      for (int k = 1; k < DEPTH; k++) begin
        r_wr[k]  <= r_wr[k-1];
        r_ld[k]  <= r_ld[k-1];
        r_rd[k]  <= r_rd[k-1];
        r_rs1[k] <= r_rs1[k-1];
        r_rs2[k] <= r_rs2[k-1];
      end
    end
  end

  always_comb begin
    bus.o_pc_write     = 1'b1;
    bus.o_if_id_write  = 1'b1;
    bus.o_if_id_flush  = 1'b0;
    bus.o_id_ex_bubble = 1'b0;
    if (bus.i_mem_stall) begin
      bus.o_pc_write    = 1'b0;
      bus.o_if_id_write = 1'b0;
    end else if (bus.i_branch_taken) begin
      bus.o_if_id_flush  = 1'b1;
      bus.o_id_ex_bubble = 1'b1;
    end else if (w_haz) begin
      bus.o_pc_write     = 1'b0;
      bus.o_if_id_write  = 1'b0;
      bus.o_id_ex_bubble = 1'b1;
    end
  end

  assign bus.o_fwd_sel_a   = fwd_pick(r_rs1[0]);
  assign bus.o_fwd_sel_b   = fwd_pick(r_rs2[0]);
  assign bus.o_stall_count = r_stall_cnt;
  assign bus.o_flush_count = r_flush_cnt;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register address width.
REQ-002 SHALL have parameter DEPTH, default 3: tracked post-ID slots (slot 0 = EX, slot DEPTH-1 = WB); legal 3..8.
REQ-003 SHALL have parameter LOAD_LAT, default 1: extra cycles beyond EX before load data is forwardable; legal 1..DEPTH-1.
REQ-004 SHALL have parameter BR_STAGE, default 1: slot in which branch_taken is resolved; legal 1..DEPTH-1.
REQ-005 SHALL have parameter CNT_W, default 32: performance counter width. SELW = clog2(DEPTH).
REQ-006 SHALL have ports: clk in 1, clock; reset in 1, one clock, reset asynchronous active-low.
REQ-007 SHALL have ports: mem_stall in 1 (global freeze); branch_taken in 1 (branch in slot BR_STAGE taken); id_valid in 1.
REQ-008 SHALL have ports: id_rs1, id_rs2, id_rd in REG_AW; id_use_rs1, id_use_rs2, id_reg_write, id_mem_read in 1.
REQ-009 SHALL have outputs: pc_write, if_id_write, if_id_flush, id_ex_bubble (1 each); fwd_sel_a, fwd_sel_b (SELW).
REQ-010 SHALL have outputs: stall_count, flush_count (CNT_W each).

Function
REQ-011 SHALL hold per slot: valid, rd, wr, ld, rs1, rs2; rs1/rs2 stored as 0 when the matching use bit is low.
REQ-012 Slot k (k>=1) SHALL be "ready" when valid and wr and (!ld or k >= 1+LOAD_LAT).
REQ-013 fwd_sel_a SHALL be the smallest k in 1..DEPTH-1 with slot k valid, wr, rd==slot0.rs1, rd!=0; else 0 (regfile). fwd_sel_b likewise for rs2. Combinational.
REQ-014 Hazard stall SHALL assert when id_valid and, for a used source rs!=0, the youngest slot j in 0..DEPTH-2 with valid, wr, rd==rs has ld=1 and j < LOAD_LAT.
REQ-015 Each non-frozen cycle slots SHALL shift k->k+1; slot DEPTH-1 retires.
REQ-016 Slot 0 SHALL load the ID instruction when id_valid and no hazard stall and no flush; otherwise SHALL load a bubble (valid=0) and id_ex_bubble=1.
REQ-017 Hazard stall: pc_write=0, if_id_write=0, ID fields held by upstream; stall_count +1 per stall cycle.
REQ-018 branch_taken (mem_stall low): slots 0..BR_STAGE-1 SHALL be invalidated in the same shift (become bubbles at 1..BR_STAGE), slot 0 loads a bubble, if_id_flush=1, pc_write=1, flush_count +1.
REQ-019 Priority: mem_stall > branch_taken > hazard stall; a hazard stall coincident with branch_taken SHALL not be counted.
REQ-020 mem_stall=1: all slots and counters frozen, pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0, branch_taken ignored.
REQ-021 No hazard or event: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
REQ-022 Counters SHALL saturate at all-ones, never wrap.
REQ-023 Register x0 (rd==0) SHALL never cause a stall or forward.
REQ-024 Forward select SHALL never point at a non-ready slot; this is guaranteed by REQ-014.

Reset
REQ-025 reset low SHALL asynchronously clear all slot valid bits and both counters; outputs then: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, fwd_sel_a=fwd_sel_b=0.
REQ-026 reset asserted mid-stall or mid-flush SHALL discard that event; first cycle after release behaves as an empty pipeline.

Verification
REQ-027 Defaults: ld x5 then add x6,x5,x7 -> one stall cycle (pc_write=0, id_ex_bubble=1, stall_count=1), then fwd_sel_a=2 in the add's EX cycle.
REQ-028 add x5 then sub x8,x5,x5 -> no stall; fwd_sel_a=fwd_sel_b=1.
REQ-029 add x5; add x5; or x9,x5,x0 -> fwd_sel_a=1 (youngest wins), fwd_sel_b=0.
REQ-030 DEPTH=5, LOAD_LAT=3: ld x3 then use x3 -> exactly 3 stall cycles, then fwd_sel=4.
REQ-031 branch_taken with slot 0 valid (BR_STAGE=1) -> if_id_flush=1, flushed instruction never appears in fwd_sel, flush_count=1; mem_stall held 4 cycles mid-load-stall -> state and counters unchanged, stall resumes after.
REQ-032 CNT_W=4, 20 consecutive stall cycles -> stall_count=15; rd=x0 load followed by x0 use -> no stall.
